pwm_prescaler_mc: RTL and testbench



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_prescaler_ch.sv | 128 ++++++++++++
 rtl/pwm_prescaler_mc.sv | 60 ++++++
 tb/tb_pwm_prescaler_mc.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants for the PWM prescaler family.
//   DEFAULT_WIDTH : default divisor/counter width used by the prescalers
//   mode_e        : per-channel operating mode (free-run or one-shot)
// No ports; imported by pwm_prescaler_ch and pwm_prescaler_mc.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Encoding matches the raw oneshot input bit so it can be cast directly.
    typedef enum logic {
        MODE_FREE    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

endpackage

// File: rtl/pwm_prescaler_ch.sv
// ---------------------------------------------------------------------------
// pwm_prescaler_ch
// One prescaler channel: produces a one-cycle tick every div_act+1 active
// cycles, with a shadowed divisor that applies at rollover and an optional
// one-shot mode.
// Ports:
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_en      : count enable (level)
//   i_clr     : synchronous clear strobe
//   i_oneshot : mode select, 0 = free-run, 1 = one-shot
//   i_start   : one-shot start strobe (ignored in free-run)
//   i_div_wr  : divisor write strobe
//   i_div_in  : new divisor value
//   o_tick    : registered one-cycle tick
//   o_busy    : one-shot running flag
//   o_cnt     : current counter value
// ---------------------------------------------------------------------------
module pwm_prescaler_ch
    import pwm_pkg::*;
#(
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic             i_div_wr,
    input  logic [WIDTH-1:0] i_div_in,
    output logic             o_tick,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] L_DIV_RESET = WIDTH'(DIV_RESET);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_divAct;
    logic [WIDTH-1:0] r_divShd;
    logic             r_pend;
    logic             r_busy;
    logic             r_tick;

    logic w_isOneshot;
    logic w_act;
    logic w_roll;

    // In one-shot mode the channel only counts while a run is in progress;
    // in free-run it counts whenever enabled.
    assign w_isOneshot = (mode_e'(i_oneshot) == MODE_ONESHOT);
    assign w_act       = i_en & (~w_isOneshot | r_busy);
    assign w_roll      = w_act & (r_cnt == r_divAct);

    // Counter, tick and busy flag. Clear beats start, start beats normal
    // counting. A start landing on the rollover edge still emits that tick
    // but keeps busy set because a fresh run begins from zero. Outside the
    // one-shot mode busy is forced low, which also covers the 1->0 mode
    // change. If the divisor was shrunk below the count while idle, the
    // counter simply runs on and wraps through zero before matching again.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
        end else if (w_isOneshot && i_start) begin
            r_cnt  <= '0;
            r_tick <= w_roll;
            r_busy <= 1'b1;
        end else if (w_roll) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_act) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
            if (!w_isOneshot) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Divisor shadowing. A write while counting only lands in the shadow and
    // is marked pending so the running period is never cut short; it is
    // promoted at the next rollover. A write that coincides with a rollover,
    // or arrives while the channel is idle, takes effect at once. Clear
    // promotes the shadow (or the simultaneous write) and drops the pending
    // flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_divAct <= L_DIV_RESET;
            r_divShd <= L_DIV_RESET;
            r_pend   <= 1'b0;
        end else if (i_clr) begin
            r_pend <= 1'b0;
            if (i_div_wr) begin
                r_divAct <= i_div_in;
                r_divShd <= i_div_in;
            end else begin
                r_divAct <= r_divShd;
            end
        end else if (i_div_wr) begin
            r_divShd <= i_div_in;
            if (w_roll || !w_act) begin
                r_divAct <= i_div_in;
                r_pend   <= 1'b0;
            end else begin
                r_pend <= 1'b1;
            end
        end else if (w_roll && r_pend) begin
            r_divAct <= r_divShd;
            r_pend   <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/pwm_prescaler_mc.sv
// ---------------------------------------------------------------------------
// pwm_prescaler_mc
// Multi-channel PWM prescaler: NCH fully independent prescaler channels,
// each with its own WIDTH-bit divisor, feeding tick enables to the PWM
// counter/compare channels.
// Ports:
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_en      : per-channel count enable
//   i_clr     : per-channel synchronous clear strobe
//   i_oneshot : per-channel mode, 0 = free-run, 1 = one-shot
//   i_start   : per-channel one-shot start strobe
//   i_div_wr  : per-channel divisor write strobe
//   i_div_in  : packed divisors, channel i at [i*WIDTH +: WIDTH]
//   o_tick    : per-channel one-cycle tick
//   o_busy    : per-channel one-shot running flag
//   o_cnt     : packed counters, channel i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module pwm_prescaler_mc
    import pwm_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DIV_RESET = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NCH-1:0]       i_en,
    input  logic [NCH-1:0]       i_clr,
    input  logic [NCH-1:0]       i_oneshot,
    input  logic [NCH-1:0]       i_start,
    input  logic [NCH-1:0]       i_div_wr,
    input  logic [NCH*WIDTH-1:0] i_div_in,
    output logic [NCH-1:0]       o_tick,
    output logic [NCH-1:0]       o_busy,
    output logic [NCH*WIDTH-1:0] o_cnt
);

    // One channel instance per bit; the packed buses are sliced per channel
    // so there is no shared state between channels.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_prescaler_ch #(
            .WIDTH     (WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_en      (i_en[g]),
            .i_clr     (i_clr[g]),
            .i_oneshot (i_oneshot[g]),
            .i_start   (i_start[g]),
            .i_div_wr  (i_div_wr[g]),
            .i_div_in  (i_div_in[g*WIDTH +: WIDTH]),
            .o_tick    (o_tick[g]),
            .o_busy    (o_busy[g]),
            .o_cnt     (o_cnt[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_pwm_prescaler_mc.sv
// ---------------------------------------------------------------------------
// tb_pwm_prescaler_mc
// Directed-vector bench for pwm_prescaler_mc with a scoreboard queue: each
// stimulus cycle pushes the hand-computed expected channel state, and a
// monitor pops and compares it at the falling edge after the clock edge.
// ---------------------------------------------------------------------------
module tb_pwm_prescaler_mc;

    localparam int NCH   = 4;
    localparam int WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       oneshot;
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       divWr;
    logic [NCH*WIDTH-1:0] divIn;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       busy;
    logic [NCH*WIDTH-1:0] cnt;

    typedef struct {
        int               tag;
        int               ch;
        logic             tick;
        logic             busy;
        logic [WIDTH-1:0] cnt;
        string            name;
    } exp_t;

    exp_t expQ[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    pwm_prescaler_mc #(
        .NCH       (NCH),
        .WIDTH     (WIDTH),
        .DIV_RESET (0)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_en      (en),
        .i_clr     (clr),
        .i_oneshot (oneshot),
        .i_start   (start),
        .i_div_wr  (divWr),
        .i_div_in  (divIn),
        .o_tick    (tick),
        .o_busy    (busy),
        .o_cnt     (cnt)
    );

    // Free-running clock and a rising-edge counter used to tag expectations.
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, got cyc=%0d want end of stimulus", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input int ch, input logic eTick, input logic eBusy,
                               input logic [WIDTH-1:0] eCnt, input string nm);
        vectors++;
        if (tick[ch] !== eTick || busy[ch] !== eBusy || cnt[ch*WIDTH +: WIDTH] !== eCnt) begin
            miscompares++;
            $display("[TB] FAIL %s ch%0d @cyc %0d: got tick=%b busy=%b cnt=%0d, want tick=%b busy=%b cnt=%0d",
                     nm, ch, cyc, tick[ch], busy[ch], cnt[ch*WIDTH +: WIDTH], eTick, eBusy, eCnt);
        end
    endtask

    // Monitor: at each falling edge compare every expectation due for the
    // rising edge just passed; anything older was missed and counts as bad.
    initial forever begin
        exp_t e;
        @(negedge clk);
        while (expQ.size() > 0 && expQ[0].tag <= cyc) begin
            e = expQ.pop_front();
            if (e.tag < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s ch%0d stale: got check at cyc %0d, want cyc %0d", e.name, e.ch, cyc, e.tag);
            end else begin
                checkOutput(e.ch, e.tick, e.busy, e.cnt, e.name);
            end
        end
    end

    task automatic expectCh(input int ch, input logic t, input logic b, input int c, input string nm);
        exp_t e;
        e.tag  = cyc + 1;
        e.ch   = ch;
        e.tick = t;
        e.busy = b;
        e.cnt  = WIDTH'(c);
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic setDiv(input int ch, input int val);
        divIn[ch*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    // Let one rising edge consume the current inputs, then drop the strobes.
    task automatic applyStimulus();
        @(negedge clk);
        clr   = '0;
        start = '0;
        divWr = '0;
    endtask

    initial begin
        int cnt3[20];
        int divs[NCH];
        int c;
        int j;

        rstN    = 1'b0;
        en      = '0;
        clr     = '0;
        oneshot = '0;
        start   = '0;
        divWr   = '0;
        divIn   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) checkOutput(ch, 1'b0, 1'b0, 0, "resetState");
        rstN = 1'b1;

        // Free-run, divisor 3 loaded while idle
        setDiv(0, 3);
        divWr[0] = 1'b1;
        expectCh(0, 1'b0, 1'b0, 0, "idleLoad");
        applyStimulus();
        en[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            expectCh(0, (k % 4) == 0, 1'b0, k % 4, "freeRun3");
            applyStimulus();
        end
        en[0] = 1'b0;
        expectCh(0, 1'b0, 1'b0, 2, "enDropHold");
        applyStimulus();
        clr[0] = 1'b1;
        expectCh(0, 1'b0, 1'b0, 0, "clr0");
        applyStimulus();

        // Divisor 0 ticks on every active cycle
        en[1] = 1'b1;
        repeat (5) begin
            expectCh(1, 1'b1, 1'b0, 0, "div0Tick");
            applyStimulus();
        end
        en[1] = 1'b0;
        expectCh(1, 1'b0, 1'b0, 0, "div0Drop");
        applyStimulus();

        // Shadowed write mid-period, then write exactly on rollover
        setDiv(0, 5);
        divWr[0] = 1'b1;
        expectCh(0, 1'b0, 1'b0, 0, "loadDiv5");
        applyStimulus();
        cnt3 = '{1, 2, 3, 4, 5, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 4, 0};
        en[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin
                setDiv(0, 2);
                divWr[0] = 1'b1;
            end
            if (k == 15) begin
                setDiv(0, 4);
                divWr[0] = 1'b1;
            end
            expectCh(0, cnt3[k-1] == 0, 1'b0, cnt3[k-1], "shadowDiv");
            applyStimulus();
        end
        en[0]  = 1'b0;
        clr[0] = 1'b1;
        expectCh(0, 1'b0, 1'b0, 0, "clr0b");
        applyStimulus();

        // One-shot, divisor 4
        oneshot[2] = 1'b1;
        en[2]      = 1'b1;
        setDiv(2, 4);
        divWr[2] = 1'b1;
        expectCh(2, 1'b0, 1'b0, 0, "osLoad");
        applyStimulus();
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b1, 0, "osStart");
        applyStimulus();
        for (int k = 1; k <= 4; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount");
            applyStimulus();
        end
        expectCh(2, 1'b1, 1'b0, 0, "osTick");
        applyStimulus();
        repeat (3) begin
            expectCh(2, 1'b0, 1'b0, 0, "osIdle");
            applyStimulus();
        end

        // Restart at cnt=2
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b1, 0, "osStart2");
        applyStimulus();
        for (int k = 1; k <= 2; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount2");
            applyStimulus();
        end
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b1, 0, "osRestart");
        applyStimulus();
        for (int k = 1; k <= 4; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount3");
            applyStimulus();
        end
        expectCh(2, 1'b1, 1'b0, 0, "osTick2");
        applyStimulus();

        // Start coincident with rollover keeps busy and still ticks
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b1, 0, "osStart4");
        applyStimulus();
        for (int k = 1; k <= 4; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount4");
            applyStimulus();
        end
        start[2] = 1'b1;
        expectCh(2, 1'b1, 1'b1, 0, "osStartOnRoll");
        applyStimulus();
        for (int k = 1; k <= 4; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount5");
            applyStimulus();
        end
        expectCh(2, 1'b1, 1'b0, 0, "osTick3");
        applyStimulus();

        // Clear beats start at cnt=3
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b1, 0, "osStart6");
        applyStimulus();
        for (int k = 1; k <= 3; k++) begin
            expectCh(2, 1'b0, 1'b1, k, "osCount6");
            applyStimulus();
        end
        clr[2]   = 1'b1;
        start[2] = 1'b1;
        expectCh(2, 1'b0, 1'b0, 0, "clrBeatsStart");
        applyStimulus();
        expectCh(2, 1'b0, 1'b0, 0, "afterClr");
        applyStimulus();

        // Four channels, divisors 1,2,3,7; clr[2] mid-run
        divs    = '{1, 2, 3, 7};
        oneshot = '0;
        en      = '0;
        clr     = '1;
        divWr   = '1;
        for (int ch = 0; ch < NCH; ch++) begin
            setDiv(ch, divs[ch]);
            expectCh(ch, 1'b0, 1'b0, 0, "mcLoad");
        end
        applyStimulus();
        en = '1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) clr[2] = 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (ch == 2 && k >= 10) begin
                    j = k - 10;
                    expectCh(ch, j > 0 && (j % 4) == 0, 1'b0, j % 4, "mcClr2");
                end else begin
                    c = k % (divs[ch] + 1);
                    expectCh(ch, c == 0, 1'b0, c, "mcRun");
                end
            end
            applyStimulus();
        end

        // Idle shrink below the count: counter wraps through zero, then ticks
        en       = '0;
        clr[3]   = 1'b1;
        divWr[3] = 1'b1;
        setDiv(3, 7);
        expectCh(3, 1'b0, 1'b0, 0, "wrapPrep");
        applyStimulus();
        en[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expectCh(3, 1'b0, 1'b0, k, "wrapCount");
            applyStimulus();
        end
        en[3]    = 1'b0;
        divWr[3] = 1'b1;
        setDiv(3, 2);
        expectCh(3, 1'b0, 1'b0, 5, "idleShrink");
        applyStimulus();
        en[3] = 1'b1;
        for (int n = 1; n <= 254; n++) begin
            if (n < 254) expectCh(3, 1'b0, 1'b0, (5 + n) % 256, "wrapRun");
            else         expectCh(3, 1'b1, 1'b0, 0, "wrapTick");
            applyStimulus();
        end

        // Asynchronous reset mid-count, then divisor returns to DIV_RESET=0
        en = '1;
        repeat (3) applyStimulus();
        #2 rstN = 1'b0;
        #1;
        for (int ch = 0; ch < NCH; ch++) checkOutput(ch, 1'b0, 1'b0, 0, "asyncReset");
        @(negedge clk);
        rstN = 1'b1;
        for (int ch = 0; ch < NCH; ch++) expectCh(ch, 1'b1, 1'b0, 0, "postResetDiv0");
        applyStimulus();
        en = '0;

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) begin
            vectors     += expQ.size();
            miscompares += expQ.size();
            $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
